// File: rtl/mdu_if.sv
// MDU E-stage bus: op/operands into the unit, start/busy and HI/LO back out.
// o_start is the acceptance strobe for i_op; i_op is only consumed while o_busy is low.
interface mdu_if;
  logic [3:0]  i_op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        o_start;
  logic        o_busy;
  logic [31:0] o_HI;
  logic [31:0] o_LO;

  modport master (output i_op, i_A, i_B, input o_start, o_busy, o_HI, o_LO);
  modport slave  (input i_op, i_A, i_B, output o_start, o_busy, o_HI, o_LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO; madd/maddu are built only when
// MDU_MADD_EN is defined, otherwise ops 7/8 decode as none.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  i_clk,
  input  logic  i_reset,
  mdu_if.slave  bus,
  output logic  o_dbg_state
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [3:0]  r_cnt;
  logic        [3:0]  r_op;
  logic        [31:0] r_a;
  logic        [31:0] r_b;
  logic        [31:0] r_hi;
  logic        [31:0] r_lo;
  logic               w_is_md;
  logic               w_start;
  logic               w_busy;
  logic        [31:0] w_hi_nxt;
  logic        [31:0] w_lo_nxt;
  logic signed [63:0] w_a_s;
  logic signed [63:0] w_b_s;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  always_comb begin
    w_is_md = 1'b0;
    case (bus.i_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_is_md = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  w_is_md = 1'b1;
`endif
      default:                            w_is_md = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_is_md) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_start     = (r_state == S_IDLE) && w_is_md && !i_reset;
    w_busy      = (r_state == S_BUSY);
    o_dbg_state = r_state;
  end

  assign bus.o_start = w_start;
  assign bus.o_busy  = w_busy;
  assign bus.o_HI    = r_hi;
  assign bus.o_LO    = r_lo;

  assign w_a_s    = {{32{r_a[31]}}, r_a};
  assign w_b_s    = {{32{r_b[31]}}, r_b};
  assign w_prod_s = w_a_s * w_b_s;
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Result of the latched op, consumed only on the final busy cycle
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    case (r_op)
      OP_MULT:  {w_hi_nxt, w_lo_nxt} = $unsigned(w_prod_s);
      OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
      OP_DIV: begin
        if (r_b != 32'd0) begin
          // The one signed overflow case is pinned rather than left to the divider
          if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
            w_lo_nxt = 32'h8000_0000;
            w_hi_nxt = 32'd0;
          end else begin
            w_lo_nxt = 32'($signed(r_a) / $signed(r_b));
            w_hi_nxt = 32'($signed(r_a) % $signed(r_b));
          end
        end
      end
      OP_DIVU: begin
        if (r_b != 32'd0) begin
          w_lo_nxt = r_a / r_b;
          w_hi_nxt = r_a % r_b;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + $unsigned(w_prod_s);
      OP_MADDU: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 4'd0;
      r_op  <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (w_start) begin
      r_op  <= bus.i_op;
      r_a   <= bus.i_A;
      r_b   <= bus.i_B;
      r_cnt <= (bus.i_op == OP_DIV || bus.i_op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
    end else if (r_state == S_BUSY) begin
      if (r_cnt == 4'd0) begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (bus.i_op == OP_MTHI) begin
      r_hi <= bus.i_A;
    end else if (bus.i_op == OP_MTLO) begin
      r_lo <= bus.i_A;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: stimulus pushes expected {HI,LO} and busy length,
// a monitor pops and compares whenever o_busy falls.
module tb_mdu;
  logic clk;
  logic rst;
  logic dbg;

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_dbg_state (dbg)
  );

  logic [63:0] exp_q[$];
  int          exp_len_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_start);
    bus.i_op = op;
    bus.i_A  = a;
    bus.i_B  = b;
    @(negedge clk);
    chk("start", 64'(bus.o_start), 64'(exp_start));
    @(posedge clk);
    #1;
    bus.i_op = 4'd0;
  endtask

  task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_q.push_back({hi, lo});
    exp_len_q.push_back(len);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_done", 64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin
    logic prev_busy;
    int   len;
    logic [63:0] e;
    int   el;
    prev_busy = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) len++;
      if (prev_busy === 1'b1 && bus.o_busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus.o_HI, bus.o_LO}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e  = exp_q.pop_front();
          el = exp_len_q.pop_front();
          chk("hilo", {bus.o_HI, bus.o_LO}, e);
          chk("busy_len", 64'(len), 64'(el));
        end
        len = 0;
      end
      prev_busy = bus.o_busy;
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    bus.i_op = 4'd0;
    bus.i_A  = 32'd0;
    bus.i_B  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi",    64'(bus.o_HI),    64'd0);
    chk("rst_lo",    64'(bus.o_LO),    64'd0);
    chk("rst_busy",  64'(bus.o_busy),  64'd0);
    chk("rst_start", 64'(bus.o_start), 64'd0);
    @(posedge clk);
    #1;

    // mult -1 * 2, with a mthi and a mult offered while busy
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    bus.i_op = 4'd5;
    bus.i_A  = 32'h55;
    @(negedge clk);
    chk("start_while_busy_mthi", 64'(bus.o_start), 64'd0);
    chk("busy_after_start",      64'(bus.o_busy),  64'd1);
    @(posedge clk);
    #1;
    bus.i_op = 4'd1;
    @(negedge clk);
    chk("start_while_busy_mult", 64'(bus.o_start), 64'd0);
    chk("hi_held_while_busy",    64'(bus.o_HI),    64'd0);
    bus.i_op = 4'd0;
    wait_idle();

    // mult -3 * -5, multu 0xFFFFFFFF * 2
    expect_result(32'd0, 32'd15, 5);
    issue(4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1);
    wait_idle();
    expect_result(32'd1, 32'hFFFF_FFFE, 5);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_idle();

    // divu 7/2, div -7/2, div overflow
    expect_result(32'd1, 32'd3, 10);
    issue(4'd4, 32'd7, 32'd2, 1'b1);
    wait_idle();
    expect_result(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    expect_result(32'd0, 32'h8000_0000, 10);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // mthi/mtlo then divide by zero leaves HI/LO alone
    issue(4'd5, 32'h11, 32'd0, 1'b0);
    issue(4'd6, 32'h22, 32'd0, 1'b0);
    @(negedge clk);
    chk("mthi_hi",   64'(bus.o_HI),   64'h11);
    chk("mtlo_lo",   64'(bus.o_LO),   64'h22);
    chk("mt_busy",   64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;
    expect_result(32'h11, 32'h22, 10);
    issue(4'd3, 32'd100, 32'd0, 1'b1);
    wait_idle();

    // multu aborted by reset in the third busy cycle
    expect_result(32'd0, 32'd0, 3);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bus.i_op = 4'd5;
    bus.i_A  = 32'd5;
    @(posedge clk);
    #1;
    bus.i_op = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("busy_before_abort", 64'(bus.o_busy), 64'd1);
    @(posedge clk);
    #1;
    bus.i_op = 4'd1;
    @(negedge clk);
    chk("abort_busy",       64'(bus.o_busy),  64'd0);
    chk("abort_hi",         64'(bus.o_HI),    64'd0);
    chk("abort_lo",         64'(bus.o_LO),    64'd0);
    chk("reset_blocks_start", 64'(bus.o_start), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_op = 4'd0;
    @(negedge clk);
    chk("no_start_under_reset", 64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;

    // maddu onto HI=0, LO=0xFFFFFFFF
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    expect_result(32'd1, 32'd0, 5);
    issue(4'd8, 32'd1, 32'd1, 1'b1);
    wait_idle();
`else
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("maddu_off_busy", 64'(bus.o_busy), 64'd0);
    chk("maddu_off_hilo", {bus.o_HI, bus.o_LO}, {32'd0, 32'hFFFF_FFFF});
    @(posedge clk);
    #1;
`endif

    // undefined op decodes as none
    issue(4'd9, 32'd3, 32'd3, 1'b0);
    @(negedge clk);
    chk("op9_busy", 64'(bus.o_busy), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, meaning busy-cycle count for mult/multu/madd/maddu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, meaning busy-cycle count for div/divu.
REQ-003 SHALL provide port i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port i_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; others are none.
REQ-006 SHALL provide port i_A  input  32  E-stage forwarded rs value.
REQ-007 SHALL provide port i_B  input  32  E-stage forwarded rt value.
REQ-008 SHALL provide port o_start  output  1  combinational: i_op is an accepted multi-cycle op this cycle; drives hazard-unit start input.
REQ-009 SHALL provide port o_busy  output  1  registered: multi-cycle operation in progress; drives hazard-unit busy input.
REQ-010 SHALL provide port o_HI  output  32  architectural HI.
REQ-011 SHALL provide port o_LO  output  32  architectural LO.

Function
REQ-012 SHALL implement two states: IDLE (o_busy=0) and BUSY (o_busy=1), with a 4-bit down counter.
REQ-013 In IDLE, i_op in {1,2,3,4,7,8} SHALL assert o_start in the same cycle, latch operands, and enter BUSY at the next edge with counter = N-1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-014 In BUSY, the counter SHALL decrement each cycle; when counter==0 at an edge, HI/LO SHALL commit and state SHALL return to IDLE, so o_busy is high exactly N cycles after the start cycle.
REQ-015 Committed HI/LO SHALL first be visible on o_HI/o_LO in the cycle o_busy falls; prior to that o_HI/o_LO SHALL hold old values.
REQ-016 mult: {HI,LO} = signed i_A * signed i_B (64 bit); multu: unsigned product.
REQ-017 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned.
REQ-018 div/divu with i_B==0 SHALL run the full DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-019 div with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 mthi/mtlo in IDLE SHALL write i_A to HI/LO at the next edge, single cycle, o_start=0, o_busy unchanged.
REQ-021 Any i_op received while BUSY (including mthi/mtlo) SHALL be ignored, with o_start=0; the hazard unit guarantees no md/mt/mf op reaches E while busy.
REQ-022 o_start SHALL be 0 whenever o_busy=1 or i_reset=1.

Reset
REQ-023 On i_reset at an edge: state IDLE, counter 0, o_busy=0, o_HI=0, o_LO=0, latched operands cleared.
REQ-024 Reset during BUSY SHALL abort the operation with no HI/LO commit; reset SHALL override a simultaneous start.

Configuration
REQ-025 Macro MDU_MADD_EN: when defined, op 7 madd ({HI,LO} += signed product) and op 8 maddu (unsigned) SHALL take MULT_CYCLES and commit like mult; when undefined, ops 7/8 SHALL be treated as none (o_start=0, no state change).

Verification
REQ-026 Reset, then i_op=1, A=0xFFFFFFFF, B=2 -> o_start=1 one cycle, o_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-027 i_op=4, A=7, B=2 -> o_busy high 10 cycles, then HI=1, LO=3; i_op=3, A=0xFFFFFFF9 (-7), B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-028 HI=0x11, LO=0x22 via mthi/mtlo, then div with B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-029 Start multu A=B=0xFFFFFFFF, assert i_reset in 3rd busy cycle -> next cycle o_busy=0, HI=LO=0; mthi 5 during busy (pre-reset) ignored.
REQ-030 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1,B=1 -> after 5 busy cycles HI=1, LO=0; without macro, same op -> o_start=0, HI/LO unchanged.
